// File: rtl/image_frame_buffer_pp_pkg.sv
// Types, default geometry and the bank-size helper shared by the frame buffer
// and the BNN inference core.
package image_buffer_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } fill_state_t;

    localparam int DEF_IMG_WIDTH  = 30;
    localparam int DEF_IMG_HEIGHT = 30;
    localparam int DEF_BYTE_W     = 8;
    localparam int DEF_CNT_W      = 16;

    // Pixel bits rounded up to a whole number of write beats.
    function automatic int padded_bits(input int w, input int h, input int byte_w);
        return ((w * h + byte_w - 1) / byte_w) * byte_w;
    endfunction

endpackage

// File: rtl/image_frame_buffer_pp_if.sv
// Write-stream and frame-handshake bundle between the receive path, the
// ping-pong buffer and the inference core.
interface image_frame_buffer_pp_if
    import image_buffer_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int BYTE_W     = DEF_BYTE_W,
    parameter int CNT_W      = DEF_CNT_W
);
    localparam int FRAME_BITS = padded_bits(IMG_WIDTH, IMG_HEIGHT, BYTE_W);
    localparam int ADDR_W     = $clog2(FRAME_BITS + 1);

    logic [BYTE_W-1:0]     data_in;
    logic                  write_enable;
    logic                  write_ready;
    logic [ADDR_W-1:0]     write_addr;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic                  frame_valid;
    logic                  frame_ready;
    logic [FRAME_BITS-1:0] img_out;
    logic [CNT_W-1:0]      frame_count;

    modport master (
        output data_in, write_enable, frame_ready,
        input  write_ready, write_addr, full, empty, overflow,
        input  frame_valid, img_out, frame_count
    );

    modport slave (
        input  data_in, write_enable, frame_ready,
        output write_ready, write_addr, full, empty, overflow,
        output frame_valid, img_out, frame_count
    );

endinterface

// File: rtl/image_frame_buffer_pp_bank.sv
// One frame-wide register bank: each beat-sized slice has its own write
// enable decoded from the bit address, so no wide data mux is built.
module image_bank #(
    parameter int FRAME_BITS = 904,
    parameter int BYTE_W     = 8,
    parameter int ADDR_W     = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [BYTE_W-1:0]     wdata,
    output logic [FRAME_BITS-1:0] q
);
    localparam int BEATS = FRAME_BITS / BYTE_W;

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_beat
            logic [BYTE_W-1:0] slice_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slice_reg <= '0;
                end else if (clear) begin
                    slice_reg <= '0;
                end else if (we && (addr == ADDR_W'(gi * BYTE_W))) begin
                    slice_reg <= wdata;
                end
            end

            assign q[gi*BYTE_W +: BYTE_W] = slice_reg;
        end
    endgenerate

endmodule

// File: rtl/image_frame_buffer_pp.sv
// Ping-pong image buffer: one bank fills from the byte stream while the other
// is presented to the inference core; banks swap by index, never by copy.
module image_frame_buffer_pp
    import image_buffer_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int BYTE_W     = DEF_BYTE_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_buffer,
    image_frame_buffer_pp_if.slave   bus
);
    localparam int FRAME_BITS = padded_bits(IMG_WIDTH, IMG_HEIGHT, BYTE_W);
    localparam int ADDR_W     = $clog2(FRAME_BITS + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BITS - BYTE_W);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BYTE_W);

    fill_state_t       state_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic              sel_reg;
    logic              frame_valid_reg;
    logic              overflow_reg;
    logic [CNT_W-1:0]  frame_count_reg;

    logic accept;
    logic last_beat;
    logic frame_release;
    logic swap;
    logic bank_we;
    logic [FRAME_BITS-1:0] bank0_q;
    logic [FRAME_BITS-1:0] bank1_q;

    assign accept        = bus.write_enable && (state_reg == FILL);
    assign last_beat     = accept && (ptr_reg == LAST_ADDR);
    assign frame_release = frame_valid_reg && bus.frame_ready;
    // A finished fill hands over immediately when the presented bank is free
    // or being released in the same cycle; otherwise STALL waits for release.
    assign swap = (last_beat && (!frame_valid_reg || bus.frame_ready)) ||
                  ((state_reg == STALL) && frame_release);
    assign bank_we = accept && !clear_buffer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= FILL;
            ptr_reg         <= '0;
            sel_reg         <= 1'b0;
            frame_valid_reg <= 1'b0;
            overflow_reg    <= 1'b0;
            frame_count_reg <= '0;
        end else if (clear_buffer) begin
            state_reg       <= FILL;
            ptr_reg         <= '0;
            sel_reg         <= 1'b0;
            frame_valid_reg <= 1'b0;
            overflow_reg    <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            if (bus.write_enable && (state_reg == STALL)) begin
                overflow_reg <= 1'b1;
            end
            if (accept) begin
                ptr_reg <= last_beat ? '0 : ptr_reg + STEP;
            end
            if (swap) begin
                sel_reg         <= ~sel_reg;
                frame_valid_reg <= 1'b1;
                frame_count_reg <= frame_count_reg + 1'b1;
                state_reg       <= FILL;
            end else begin
                if (frame_release) begin
                    frame_valid_reg <= 1'b0;
                end
                if (last_beat) begin
                    state_reg <= STALL;
                end
            end
        end
    end

    image_bank #(
        .FRAME_BITS (FRAME_BITS),
        .BYTE_W     (BYTE_W),
        .ADDR_W     (ADDR_W)
    ) u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_buffer),
        .we    (bank_we && !sel_reg),
        .addr  (ptr_reg),
        .wdata (bus.data_in),
        .q     (bank0_q)
    );

    image_bank #(
        .FRAME_BITS (FRAME_BITS),
        .BYTE_W     (BYTE_W),
        .ADDR_W     (ADDR_W)
    ) u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_buffer),
        .we    (bank_we && sel_reg),
        .addr  (ptr_reg),
        .wdata (bus.data_in),
        .q     (bank1_q)
    );

    // The presented bank is always the one not being filled.
    assign bus.img_out     = sel_reg ? bank0_q : bank1_q;
    assign bus.write_ready = (state_reg == FILL);
    assign bus.full        = (state_reg == STALL);
    assign bus.write_addr  = ptr_reg;
    assign bus.empty       = (ptr_reg == '0) && !frame_valid_reg;
    assign bus.overflow    = overflow_reg;
    assign bus.frame_valid = frame_valid_reg;
    assign bus.frame_count = frame_count_reg;

`ifndef SYNTHESIS
    a_ptr_bound: assert property (@(posedge clk) disable iff (!rst_n)
        ptr_reg <= LAST_ADDR);
    a_no_stall_write: assert property (@(posedge clk) disable iff (!rst_n)
        !(bank_we && (state_reg == STALL)));
    a_count_on_swap: assert property (@(posedge clk) disable iff (!rst_n)
        (!clear_buffer && !swap) |=> $stable(frame_count_reg));
`endif

endmodule
